reg_writeback_arbiter: RTL
==========================

// Module: reg_writeback_arbiter
// PURPOSE
//  Write-side front end of the 32x32 register file: merges ALU results (no backpressure) and
//  load results (valid/ready) into the single RegWrite/regW/Wdat port. Buffers loads in a small
//  FIFO, starvation-guards them against continuous ALU traffic, and tracks outstanding load
//  destinations in a 32-bit scoreboard for hazard detection.
// PARAMETERS
//  LDQ_DEPTH  2   load FIFO entries (power of 2, >=2)
//  MAX_WAIT   4   cycles the load-FIFO head may be bypassed by ALU writes before alu_hold forces a drain
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  alu_valid  in   1   ALU result this cycle
//  alu_reg    in   5   ALU destination
//  alu_dat    in   32  ALU result
//  alu_hold   out  1   upstream must not present alu_valid next cycle (load drain slot)
//  ld_valid   in   1   load result offered
//  ld_ready   out  1   FIFO not full; transfer on ld_valid&&ld_ready
//  ld_reg     in   5   load destination
//  ld_dat     in   32  load data
//  ld_issue   in   1   load issued; set pending[ld_issue_reg]
//  ld_issue_reg in 5   destination of issued load
//  RegWrite   out  1   register-file write enable (registered)
//  regW       out  5   register-file write address (registered)
//  Wdat       out  32  register-file write data (registered)
//  pending    out  32  scoreboard: bit r=1 while a load to r is issued but not yet written
// BEHAVIOUR
//  - Reset: FIFO empty, wait counter 0, pending=0, RegWrite=0, regW=0, Wdat=0, alu_hold=0, ld_ready=1.
//  - Latency: selected source appears on RegWrite/regW/Wdat exactly 1 cycle after selection;
//    register file commits on the following edge. ALU result -> regfile = 2 edges.
//  - Selection each cycle: alu_valid wins; else FIFO head popped if non-empty; else RegWrite=0.
//  - Load with empty FIFO and no alu_valid still enters FIFO first (no cut-through): min load latency 2 cycles.
//  - Writes to reg 0: RegWrite driven 0 (filtered here; source still consumed/popped).
//  - Starvation: wait_cnt increments each cycle FIFO non-empty and head not popped; resets to 0 on pop
//    or empty. When wait_cnt==MAX_WAIT-1, alu_hold=1 (registered, one cycle); next cycle head is popped
//    unconditionally. alu_valid during hold is a protocol violation: result dropped, sim $error.
//  - FIFO: ld_ready = !full. Simultaneous push and pop when full is not allowed (ready=0); when
//    empty push+pop cannot occur (no cut-through). Pointers wrap modulo LDQ_DEPTH; count 0..LDQ_DEPTH.
//  - Scoreboard: ld_issue sets bit; write of load to r clears bit at the cycle RegWrite asserts.
//    Same-cycle set and clear of same r: set wins (new outstanding load). r=0 never set.
//  - ALU write to a pending register is an upstream hazard violation: sim $error, write still performed.
//  - rst mid-operation: FIFO contents and pending discarded immediately; any in-flight RegWrite cleared.
// CONFIGURATION
//  WB_FWD_EN defined: adds inputs rdA,rdB[4:0] and outputs fwdA_hit,fwdB_hit, fwdA_dat,fwdB_dat[31:0];
//   hit=RegWrite && regW==rdX && rdX!=0, dat=Wdat (combinational bypass of the write being committed).
//  WB_FWD_EN undefined: those ports absent; consumers read the register file one cycle later.
// STRUCTURE
//  - Shared package cpu_pkg: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, typedef wb_req_t {reg, dat}.
//  - Sub-module wb_ldq_fifo (LDQ_DEPTH entries of wb_req_t, push/pop/full/empty/count); rest inline.
// TESTING
//  - ALU only: alu_valid, reg 5, dat 0xDEADBEEF -> next cycle RegWrite=1, regW=5, Wdat=0xDEADBEEF.
//  - Load path: ld_issue r9 -> pending[9]=1; ld_valid r9 0x1234 -> RegWrite r9 two cycles later, pending[9]=0 same cycle.
//  - Backpressure: ALU every cycle, push 2 loads -> ld_ready=0 after 2nd; alu_hold pulses after MAX_WAIT=4 waits, head drains.
//  - Zero reg: alu_valid reg 0 dat 0xFFFFFFFF -> RegWrite stays 0; load to r0 popped, RegWrite 0.
//  - Reset mid-flight: 2 loads queued, pending!=0, assert rst -> pending=0, ld_ready=1, no further RegWrite.
//  - WB_FWD_EN: RegWrite r3 0xA5A5A5A5 with rdA=3, rdB=0 -> fwdA_hit=1 dat 0xA5A5A5A5, fwdB_hit=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg: shared register-file widths and the write-back request record      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     dat;
   } wb_req_t;

   // r0 is hard-wired zero, so a write to it is never a real write.
   function automatic logic wb_enable(input logic [REG_ADDR_W-1:0] rd);
      return rd != '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_writeback_arbiter_if: ALU/load write-back bus; forwarding under WB_FWD_EN|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface reg_writeback_arbiter_if;
   import cpu_pkg::*;

   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0]     alu_dat;
   logic                  alu_hold;
   logic                  ld_valid;
   logic                  ld_ready;
   logic [REG_ADDR_W-1:0] ld_reg;
   logic [DATA_W-1:0]     ld_dat;
   logic                  ld_issue;
   logic [REG_ADDR_W-1:0] ld_issue_reg;
   logic                  RegWrite;
   logic [REG_ADDR_W-1:0] regW;
   logic [DATA_W-1:0]     Wdat;
   logic [NUM_REGS-1:0]   pending;
`ifdef WB_FWD_EN
   logic [REG_ADDR_W-1:0] rdA;
   logic [REG_ADDR_W-1:0] rdB;
   logic                  fwdA_hit;
   logic                  fwdB_hit;
   logic [DATA_W-1:0]     fwdA_dat;
   logic [DATA_W-1:0]     fwdB_dat;
`endif

   modport master (
      output alu_valid, alu_reg, alu_dat, ld_valid, ld_reg, ld_dat, ld_issue, ld_issue_reg,
`ifdef WB_FWD_EN
      output rdA, rdB,
      input  fwdA_hit, fwdB_hit, fwdA_dat, fwdB_dat,
`endif
      input  alu_hold, ld_ready, RegWrite, regW, Wdat, pending
   );

   modport slave (
      input  alu_valid, alu_reg, alu_dat, ld_valid, ld_reg, ld_dat, ld_issue, ld_issue_reg,
`ifdef WB_FWD_EN
      input  rdA, rdB,
      output fwdA_hit, fwdB_hit, fwdA_dat, fwdB_dat,
`endif
      output alu_hold, ld_ready, RegWrite, regW, Wdat, pending
   );

endinterface
`default_nettype wire

// File: rtl/wb_ldq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_ldq_fifo: DEPTH-entry load-result queue (power-of-2 depth, >=2)          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_ldq_fifo
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  wb_req_t          push_data,
   input  logic             pop,
   output wb_req_t          head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   wb_req_t          mem_q [DEPTH];
   wb_req_t          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_writeback_arbiter: merges ALU and queued load results onto the regfile  |
// | write port; WB_FWD_EN adds a two-port bypass of the committing write.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module reg_writeback_arbiter
   import cpu_pkg::*;
#(
   parameter int LDQ_DEPTH = 2,
   parameter int MAX_WAIT  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   reg_writeback_arbiter_if.slave  bus
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int CNT_W  = $clog2(LDQ_DEPTH + 1);

   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                  alu_hold_q, alu_hold_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] reg_w_q, reg_w_d;
   logic [DATA_W-1:0]     wdat_q, wdat_d;
   logic [NUM_REGS-1:0]   pending_q, pending_d;

   wb_req_t               ld_req, ldq_head;
   logic                  ldq_push, ldq_pop, ldq_full, ldq_empty;
   logic [CNT_W-1:0]      ldq_count;
   logic                  drain_slot, alu_take, ldq_bypass;

   assign ld_req.rd  = bus.ld_reg;
   assign ld_req.dat = bus.ld_dat;

   wb_ldq_fifo #(.DEPTH(LDQ_DEPTH)) u_ldq (
      .clk       (clk),
      .rst       (rst),
      .push      (ldq_push),
      .push_data (ld_req),
      .pop       (ldq_pop),
      .head      (ldq_head),
      .full      (ldq_full),
      .empty     (ldq_empty),
      .count     (ldq_count)
   );

   // The head has been bypassed MAX_WAIT times: this cycle belongs to the queue.
   assign drain_slot = (wait_cnt_q == WAIT_W'(MAX_WAIT));
   assign alu_take   = bus.alu_valid && !drain_slot;
   assign ldq_pop    = !ldq_empty && !alu_take;
   assign ldq_bypass = !ldq_empty && !ldq_pop;
   assign ldq_push   = bus.ld_valid && !ldq_full;

   always_comb begin
      wait_cnt_d  = ldq_bypass ? wait_cnt_q + WAIT_W'(1) : '0;
      alu_hold_d  = ldq_bypass && (wait_cnt_q == WAIT_W'(MAX_WAIT - 2));
      reg_write_d = 1'b0;
      reg_w_d     = reg_w_q;
      wdat_d      = wdat_q;
      pending_d   = pending_q;
      if (alu_take) begin
         reg_write_d = wb_enable(bus.alu_reg);
         reg_w_d     = bus.alu_reg;
         wdat_d      = bus.alu_dat;
      end else if (ldq_pop) begin
         reg_write_d             = wb_enable(ldq_head.rd);
         reg_w_d                 = ldq_head.rd;
         wdat_d                  = ldq_head.dat;
         pending_d[ldq_head.rd]  = 1'b0;
      end
      // Applied after the clear so a fresh issue to the same register survives.
      if (bus.ld_issue && wb_enable(bus.ld_issue_reg)) begin
         pending_d[bus.ld_issue_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q  <= '0;
         alu_hold_q  <= 1'b0;
         reg_write_q <= 1'b0;
         reg_w_q     <= '0;
         wdat_q      <= '0;
         pending_q   <= '0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         alu_hold_q  <= alu_hold_d;
         reg_write_q <= reg_write_d;
         reg_w_q     <= reg_w_d;
         wdat_q      <= wdat_d;
         pending_q   <= pending_d;
      end
   end

   assign bus.alu_hold = alu_hold_q;
   assign bus.ld_ready = !ldq_full;
   assign bus.RegWrite = reg_write_q;
   assign bus.regW     = reg_w_q;
   assign bus.Wdat     = wdat_q;
   assign bus.pending  = pending_q;

`ifdef WB_FWD_EN
   assign bus.fwdA_hit = reg_write_q && (reg_w_q == bus.rdA) && wb_enable(bus.rdA);
   assign bus.fwdB_hit = reg_write_q && (reg_w_q == bus.rdB) && wb_enable(bus.rdB);
   assign bus.fwdA_dat = wdat_q;
   assign bus.fwdB_dat = wdat_q;
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) begin
         if (bus.alu_valid && drain_slot)
            $error("alu_valid during load drain slot: ALU result dropped");
         if (alu_take && wb_enable(bus.alu_reg) && pending_q[bus.alu_reg])
            $error("ALU write to r%0d with a load outstanding", bus.alu_reg);
         if (ldq_count > CNT_W'(LDQ_DEPTH))
            $error("load queue occupancy out of range");
      end
   end
`endif

endmodule
`default_nettype wire
